// File: rtl/aes_spi_pkg.sv
// Shared constants for the SPI-fronted AES frame controller: FSM state codes,
// command bytes and the status-byte tag.
package aes_spi_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_CMD   = 3'd1;
   localparam state_t ST_KEY   = 3'd2;
   localparam state_t ST_MSG   = 3'd3;
   localparam state_t ST_START = 3'd4;
   localparam state_t ST_WAIT  = 3'd5;
   localparam state_t ST_SHIFT = 3'd6;
   localparam state_t ST_DRAIN = 3'd7;

   localparam logic [7:0] CMD_ENC    = 8'hE0;
   localparam logic [7:0] CMD_DEC    = 8'hD0;
   localparam logic [2:0] STATUS_TAG = 3'b101;
   localparam int         CMD_BITS   = 8;

   function automatic logic [7:0] status_byte(input logic dec, input int nk);
      status_byte = {dec, nk[3:0], STATUS_TAG};
   endfunction

endpackage

// File: rtl/aes_spi_frame_ctrl_if.sv
// Bus between the frame controller (master) and the AES core (slave).
interface aes_spi_frame_ctrl_if #(
   parameter int NK = 8,
   parameter int NB = 4
);
   logic [32*NK-1:0] aes_key;
   logic [32*NB-1:0] aes_msg;
   logic             aes_decrypt;
   logic             aes_start;
   logic             aes_done;
   logic [32*NB-1:0] aes_result;

   modport master (
      output aes_key, aes_msg, aes_decrypt, aes_start,
      input  aes_done, aes_result
   );

   modport slave (
      input  aes_key, aes_msg, aes_decrypt, aes_start,
      output aes_done, aes_result
   );
endinterface

// File: rtl/aes_spi_sync.sv
// Multi-flop synchronizer for one asynchronous input plus rise/fall detect
// on the synchronized level; reset loads the idle level everywhere.
module aes_spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         prev  <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/aes_spi_frame_ctrl.sv
// SPI mode-0 frame controller: command, key and message in, AES result out.
// Define AES_SPI_STATUS_EN to prefix the result with a status byte.
module aes_spi_frame_ctrl
   import aes_spi_pkg::*;
#(
   parameter int NK          = 8,
   parameter int NB          = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                spi_sclk,
   input  logic                spi_cs_n,
   input  logic                spi_mosi,
   output logic                spi_miso,
   aes_spi_frame_ctrl_if.master aes,
   output logic                busy,
   output logic                frame_err
);

   localparam int KW  = 32*NK;
   localparam int MW  = 32*NB;
`ifdef AES_SPI_STATUS_EN
   localparam int TW  = MW + 8;
`else
   localparam int TW  = MW;
`endif
   localparam int CW  = $clog2(KW);
   localparam int TCW = $clog2(TW+1);

   logic sclk_q, sclk_rise, sclk_fall;
   logic cs_q, cs_rise, cs_fall;
   logic mosi_s, mosi_rise, mosi_fall;

   aes_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(spi_sclk),
      .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
   );

   aes_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .d(spi_cs_n),
      .q(cs_q), .rise(cs_rise), .fall(cs_fall)
   );

   aes_spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d(spi_mosi),
      .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
   );

   state_t          state;
   logic [KW-1:0]   rx_sr;
   logic [KW-1:0]   rx_nxt;
   logic [CW-1:0]   rx_cnt;
   logic [TW-1:0]   tx_sr;
   logic [TW-1:0]   tx_load;
   logic [TCW-1:0]  tx_cnt;
   logic            field_last;
   logic            sync_unused;

   assign rx_nxt = {rx_sr[KW-2:0], mosi_s};
   assign sync_unused = ^{sclk_q, cs_q, mosi_rise, mosi_fall, rx_sr[KW-1]};

`ifdef AES_SPI_STATUS_EN
   assign tx_load = {status_byte(aes.aes_decrypt, NK), aes.aes_result};
`else
   assign tx_load = aes.aes_result;
`endif

   always_comb begin
      field_last = 1'b0;
      case (state)
         ST_CMD:  field_last = (rx_cnt == CW'(CMD_BITS-1));
         ST_KEY:  field_last = (rx_cnt == CW'(KW-1));
         ST_MSG:  field_last = (rx_cnt == CW'(MW-1));
         default: field_last = 1'b0;
      endcase
   end

   // A CS rise outranks every other event; it is only an error while the
   // frame is still owed input or output bits (not in IDLE or DRAIN).
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= ST_IDLE;
         rx_sr           <= '0;
         rx_cnt          <= '0;
         tx_sr           <= '0;
         tx_cnt          <= '0;
         aes.aes_key     <= '0;
         aes.aes_msg     <= '0;
         aes.aes_decrypt <= 1'b0;
         frame_err       <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (cs_rise) begin
            state <= ST_IDLE;
            if (state != ST_IDLE && state != ST_DRAIN)
               frame_err <= 1'b1;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cs_fall) begin
                     state  <= ST_CMD;
                     rx_cnt <= '0;
                  end
               end
               ST_CMD: begin
                  if (sclk_rise) begin
                     rx_sr  <= rx_nxt;
                     rx_cnt <= rx_cnt + 1'b1;
                     if (field_last) begin
                        rx_cnt <= '0;
                        if (rx_nxt[7:0] == CMD_ENC) begin
                           aes.aes_decrypt <= 1'b0;
                           state           <= ST_KEY;
                        end else if (rx_nxt[7:0] == CMD_DEC) begin
                           aes.aes_decrypt <= 1'b1;
                           state           <= ST_KEY;
                        end else begin
                           frame_err <= 1'b1;
                           state     <= ST_DRAIN;
                        end
                     end
                  end
               end
               ST_KEY: begin
                  if (sclk_rise) begin
                     rx_sr  <= rx_nxt;
                     rx_cnt <= rx_cnt + 1'b1;
                     if (field_last) begin
                        rx_cnt      <= '0;
                        aes.aes_key <= rx_nxt;
                        state       <= ST_MSG;
                     end
                  end
               end
               ST_MSG: begin
                  if (sclk_rise) begin
                     rx_sr  <= rx_nxt;
                     rx_cnt <= rx_cnt + 1'b1;
                     if (field_last) begin
                        rx_cnt      <= '0;
                        aes.aes_msg <= rx_nxt[MW-1:0];
                        state       <= ST_START;
                     end
                  end
               end
               ST_START: state <= ST_WAIT;
               ST_WAIT: begin
                  if (aes.aes_done) begin
                     tx_sr  <= tx_load;
                     tx_cnt <= '0;
                     state  <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (sclk_fall) begin
                     tx_sr  <= tx_sr << 1;
                     tx_cnt <= tx_cnt + 1'b1;
                     if (tx_cnt == TCW'(TW-1))
                        state <= ST_DRAIN;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign spi_miso      = (state == ST_SHIFT) ? tx_sr[TW-1] : 1'b0;
   assign aes.aes_start = (state == ST_START);
   assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_aes_spi_frame_ctrl.sv
// Bench for aes_spi_frame_ctrl: known-answer frames through a stub AES core,
// plus error, abort and mid-frame reset sequences.
module tb_aes_spi_frame_ctrl;

`ifdef AES_SPI_STATUS_EN
   localparam int NK = 4;
   localparam int TW = 136;
`else
   localparam int NK = 8;
   localparam int TW = 128;
`endif
   localparam int KW   = 32*NK;
   localparam int HALF = 4;

   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] K256 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] K128 = {128'h0, 128'h000102030405060708090a0b0c0d0e0f};
   localparam logic [255:0] KEY   = (NK == 4) ? K128 : K256;
   localparam logic [127:0] CT    = (NK == 4) ? C128 : C256;
   localparam logic [255:0] KMASK = (NK == 4) ? {128'h0, {128{1'b1}}} : {256{1'b1}};

   typedef struct {
      logic [7:0]   cmd;
      logic [255:0] key;
      logic [127:0] msg;
      logic         dec;
      logic [135:0] miso;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
   logic miso, busy, frame_err;

   always #5 clk = ~clk;

   aes_spi_frame_ctrl_if #(.NK(NK), .NB(4)) aes_if ();

   aes_spi_frame_ctrl #(.NK(NK), .NB(4), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst),
      .spi_sclk(sclk), .spi_cs_n(cs_n), .spi_mosi(mosi),
      .spi_miso(miso), .aes(aes_if),
      .busy(busy), .frame_err(frame_err)
   );

   int n_chk = 0, n_pass = 0;
   int start_cnt = 0, done_cnt = 0, err_cnt = 0;
   logic [255:0] cap_key;
   logic [127:0] cap_msg;
   logic         cap_dec;
   logic [135:0] sb[$];
   vec_t vt[3];

   // Known-answer AES stand-in; anything else gets a fixed scramble.
   function automatic logic [127:0] core_model(input logic [255:0] k, input logic [127:0] m,
                                               input logic d);
      if (k == KEY && !d && m == PT) return CT;
      if (k == KEY && d && m == CT) return PT;
      return {m[63:0], m[127:64]} ^ k[127:0];
   endfunction

   function automatic logic [135:0] mk(input logic [7:0] st, input logic [127:0] r);
      return (TW == 136) ? {st, r} : {8'h00, r};
   endfunction

   always @(posedge clk) if (frame_err) err_cnt <= err_cnt + 1;

   initial begin
      aes_if.aes_done   = 1'b0;
      aes_if.aes_result = '0;
      forever begin
         @(negedge clk);
         if (aes_if.aes_start) begin
            start_cnt++;
            cap_key = 256'(aes_if.aes_key);
            cap_msg = aes_if.aes_msg;
            cap_dec = aes_if.aes_decrypt;
            repeat (8) @(negedge clk);
            aes_if.aes_result = core_model(cap_key, cap_msg, cap_dec);
            aes_if.aes_done   = 1'b1;
            @(negedge clk);
            aes_if.aes_done   = 1'b0;
            aes_if.aes_result = '0;
            done_cnt++;
         end
      end
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [255:0] v, input int n);
      for (int i = n-1; i >= 0; i--) begin
         mosi = v[i];
         clk_n(HALF); sclk = 1'b1;
         clk_n(HALF); sclk = 1'b0;
      end
   endtask

   task automatic recv_bits(input int n, output logic [255:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         clk_n(HALF); v = {v[254:0], miso}; sclk = 1'b1;
         clk_n(HALF); sclk = 1'b0;
      end
   endtask

   task automatic cs_low;
      cs_n = 1'b0; clk_n(HALF);
   endtask

   task automatic cs_high;
      clk_n(HALF); cs_n = 1'b1; clk_n(HALF + 2);
   endtask

   task automatic wait_done(input int d0, output bit ok);
      int t;
      t = 0;
      while (done_cnt == d0 && t < 300) begin clk_n(1); t++; end
      ok = (done_cnt != d0);
      clk_n(4);
   endtask

   task automatic run_frame(input vec_t v);
      int s0, e0, d0;
      bit ok;
      logic [255:0] rx;
      logic [135:0] exp;
      s0 = start_cnt; e0 = err_cnt; d0 = done_cnt;
      sb.push_back(v.miso);
      cs_low();
      check("busy_in_frame", busy, 1);
      send_bits(v.cmd, 8);
      send_bits(v.key, KW);
      send_bits(v.msg, 128);
      wait_done(d0, ok);
      check("done_timeout", ok, 1);
      check("start_once", start_cnt - s0, 1);
      check("key_at_start", cap_key, v.key);
      check("msg_at_start", cap_msg, v.msg);
      check("dec_at_start", cap_dec, v.dec);
      recv_bits(TW, rx);
      cs_high();
      exp = sb.pop_front();
      check("miso_result", rx, exp);
      check("no_frame_err", err_cnt - e0, 0);
      check("busy_after", busy, 0);
      check("decrypt_out", aes_if.aes_decrypt, v.dec);
   endtask

   initial begin
      int s0, e0, d0;
      bit ok;
      logic [255:0] rx;

      vt[0] = '{cmd: 8'hE0, key: KEY, msg: PT, dec: 1'b0, miso: mk(8'h25, CT)};
      vt[1] = '{cmd: 8'hD0, key: KEY, msg: CT, dec: 1'b1, miso: mk(8'hA5, PT)};
      vt[2] = '{cmd: 8'hE0, key: ~KEY & KMASK, msg: 128'h0123456789abcdeffedcba9876543210,
                dec: 1'b0, miso: 136'h0};
      vt[2].miso = mk(8'h25, core_model(vt[2].key, vt[2].msg, 1'b0));

      clk_n(3);
      check("rst_busy", busy, 0);
      check("rst_miso", miso, 0);
      check("rst_start", aes_if.aes_start, 0);
      check("rst_decrypt", aes_if.aes_decrypt, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_key", aes_if.aes_key, 0);
      check("rst_msg", aes_if.aes_msg, 0);
      rst = 1'b0;
      clk_n(4);

      for (int i = 0; i < 3; i++) run_frame(vt[i]);

      // Bad command: single error, MISO silent, busy until CS rises.
      s0 = start_cnt; e0 = err_cnt;
      cs_low();
      send_bits(8'h55, 8);
      clk_n(4);
      check("badcmd_err_once", err_cnt - e0, 1);
      recv_bits(16, rx);
      check("badcmd_miso_zero", rx, 0);
      check("badcmd_busy", busy, 1);
      cs_high();
      check("badcmd_err_total", err_cnt - e0, 1);
      check("badcmd_no_start", start_cnt - s0, 0);
      check("badcmd_idle", busy, 0);

      // Abort partway through the key field.
      s0 = start_cnt; e0 = err_cnt;
      cs_low();
      send_bits(8'hE0, 8);
      send_bits({256{1'b1}}, 100);
      cs_high();
      check("abort_err", err_cnt - e0, 1);
      check("abort_no_start", start_cnt - s0, 0);
      check("abort_key_kept", aes_if.aes_key, vt[2].key);
      check("abort_idle", busy, 0);

      // Reset in the middle of SHIFT, then a clean frame.
      d0 = done_cnt;
      cs_low();
      send_bits(vt[0].cmd, 8);
      send_bits(vt[0].key, KW);
      send_bits(vt[0].msg, 128);
      wait_done(d0, ok);
      check("rstmid_done", ok, 1);
      recv_bits(8, rx);
      check("rstmid_first_byte", rx[7:0], vt[0].miso[TW-1 -: 8]);
      rst = 1'b1; cs_n = 1'b1;
      clk_n(1);
      rst = 1'b0;
      check("rstmid_miso", miso, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_start", aes_if.aes_start, 0);
      check("rstmid_decrypt", aes_if.aes_decrypt, 0);
      check("rstmid_frame_err", frame_err, 0);
      check("rstmid_key", aes_if.aes_key, 0);
      check("rstmid_msg", aes_if.aes_msg, 0);
      clk_n(4);
      run_frame(vt[0]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

endmodule

// File: doc/aes_spi_frame_ctrl.md
AES_SPI_FRAME_CTRL -- requirements
Module: aes_spi_frame_ctrl

Interface
REQ-001 Parameter NK, default 8: key length in 32-bit words; legal values are 4, 6 and 8.
REQ-002 Parameter NB, default 4: block length in 32-bit words; fixed at 4.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth on the SPI inputs; minimum 2.
REQ-004 clk  in  1  sole clock; all logic is on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 spi_sclk, spi_cs_n, spi_mosi  in  1 each  SPI mode-0 inputs, asynchronous to clk.
REQ-007 spi_miso  out  1  serial result, MSB first.
REQ-008 aes_key  out  32*NK  key register presented to the key expansion.
REQ-009 aes_msg  out  32*NB  data block presented to the AES core.
REQ-010 aes_decrypt  out  1  selects the operation: 0 = encrypt, 1 = decrypt.
REQ-011 aes_start  out  1  one-cycle request to the AES core.
REQ-012 aes_done  in  1  one-cycle completion from the AES core.
REQ-013 aes_result  in  32*NB  AES output; valid while aes_done is high.
REQ-014 busy  out  1  high while a frame is active.
REQ-015 frame_err  out  1  one-cycle pulse on any frame error.

Function
REQ-016 The block SHALL pass spi_sclk, spi_cs_n and spi_mosi through SYNC_STAGES flops, then detect SCLK rise and fall from the synchronized signals.
REQ-017 FSM states SHALL be IDLE, CMD, KEY, MSG, START, WAIT, SHIFT and DRAIN.
REQ-018 On a synchronized CS falling edge, IDLE SHALL go to CMD and busy SHALL be set.
REQ-019 In CMD, KEY and MSG, MOSI SHALL be sampled on each SCLK rise, MSB first, for 8, 32*NK and 32*NB bits respectively.
REQ-020 Command byte 8'hE0 SHALL set aes_decrypt=0; 8'hD0 SHALL set aes_decrypt=1; any other byte SHALL pulse frame_err and enter DRAIN.
REQ-021 aes_key and aes_msg SHALL update only on completion of their full field; partial fields are never exposed.
REQ-022 aes_start SHALL pulse in the clk cycle after the last MSG bit is sampled (START state), then the FSM SHALL enter WAIT.
REQ-023 In WAIT, SCLK edges SHALL be ignored and spi_miso SHALL be 0; on aes_done, aes_result SHALL be latched into the shift register and the FSM SHALL enter SHIFT.
REQ-024 In SHIFT, the MSB SHALL be on spi_miso on entry, and each SCLK fall SHALL advance one bit.
REQ-025 After the last bit, spi_miso SHALL be 0 and further edges SHALL be ignored.
REQ-026 A synchronized CS rise in any state SHALL return the FSM to IDLE and clear busy.
REQ-027 A CS rise before SHIFT completes SHALL pulse frame_err; no aes_start SHALL be issued if the rise occurs before START.
REQ-028 An aes_done outside WAIT SHALL be ignored.
REQ-029 DRAIN SHALL hold spi_miso at 0 until CS rises.

Reset
REQ-030 rst SHALL force IDLE, and SHALL drive spi_miso, aes_start, aes_decrypt, busy and frame_err to 0 and aes_key and aes_msg to all-zero.
REQ-031 rst SHALL clear the synchronizers to the idle level (cs_n=1, sclk=0).
REQ-032 rst SHALL take priority over all other events, including mid-frame.

Configuration
REQ-033 When macro AES_SPI_STATUS_EN is defined, SHIFT SHALL first send a status byte {aes_decrypt, NK[3:0], 3'b101}, then the 32*NB result bits.
REQ-034 When AES_SPI_STATUS_EN is undefined, only the 32*NB result bits SHALL be sent.

Structure
REQ-035 Package aes_spi_pkg SHALL hold the state enum and the constants CMD_ENC=8'hE0, CMD_DEC=8'hD0 and STATUS_TAG=3'b101.
REQ-036 Sub-module aes_spi_sync SHALL implement the per-signal synchronizer and edge detector, instantiated three times.

Verification
REQ-037 NK=8; send E0, key 000102..1f and message 00112233445566778899aabbccddeeff -> one aes_start; with the core attached, MISO returns 8ea2b7ca516745bfeafc49904b496089.
REQ-038 NK=8; send D0, the same key and message 8ea2b7ca516745bfeafc49904b496089 -> aes_decrypt=1; MISO returns 00112233445566778899aabbccddeeff.
REQ-039 Command byte 8'h55 -> frame_err pulses once, no aes_start, spi_miso stays 0 until CS rises, busy then clears.
REQ-040 CS rises after 100 key bits -> frame_err pulses, no aes_start, aes_key is unchanged, FSM is in IDLE.
REQ-041 rst asserted for one cycle during SHIFT -> all outputs zero the next cycle, and a following full frame completes correctly.
REQ-042 NK=4 with AES_SPI_STATUS_EN, key 000102..0f and encrypt -> status byte 8'h25, then 69c4e0d86a7b0430d8cdb78070b4c55a.
